// File: rtl/csr_pkg.sv
// Shared machine-mode CSR definitions: addresses, write-op encoding,
// mstatus field positions, sequencer states and the read-lookup record.
package csr_pkg;

   localparam logic [11:0] CSR_MSTATUS    = 12'h300;
   localparam logic [11:0] CSR_MIE        = 12'h304;
   localparam logic [11:0] CSR_MTVEC      = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH   = 12'h340;
   localparam logic [11:0] CSR_MEPC       = 12'h341;
   localparam logic [11:0] CSR_MCAUSE     = 12'h342;
   localparam logic [11:0] CSR_MTVAL      = 12'h343;
   localparam logic [11:0] CSR_MIP        = 12'h344;
   localparam logic [11:0] CSR_MCYCLE     = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET   = 12'hB02;
   localparam logic [11:0] CSR_MHPM_BASE  = 12'hB03;
   localparam logic [11:0] CSR_MCYCLEH    = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH  = 12'hB82;
   localparam logic [11:0] CSR_MHPMH_BASE = 12'hB83;
   localparam logic [11:0] CSR_CYCLE      = 12'hC00;
   localparam logic [11:0] CSR_INSTRET    = 12'hC02;
   localparam logic [11:0] CSR_CYCLEH     = 12'hC80;
   localparam logic [11:0] CSR_INSTRETH   = 12'hC82;

   typedef enum logic [1:0] {
      WR_NONE = 2'b00,
      WR_RW   = 2'b01,
      WR_RS   = 2'b10,
      WR_RC   = 2'b11
   } wr_op_e;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;
   localparam int MSTATUS_MPP  = 11;

   // MPP is hardwired to machine mode, so it lives in the reset value and is OR-ed back on every write
   localparam logic [31:0] MSTATUS_RESET = 32'h3 << MSTATUS_MPP;
   localparam logic [31:0] MSTATUS_WMASK = (32'h1 << MSTATUS_MIE) | (32'h1 << MSTATUS_MPIE);
   localparam logic [31:0] MEPC_MASK     = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_TRAP = 2'b01,
      ST_MRET = 2'b10
   } csr_state_e;

   typedef struct packed {
      logic        hit;
      logic [31:0] data;
   } csr_rd_t;

   function automatic logic [31:0] csr_apply_op(input wr_op_e op, input logic [31:0] old_v,
                                                input logic [31:0] src);
      case (op)
         WR_RW:   return src;
         WR_RS:   return old_v | src;
         WR_RC:   return old_v & ~src;
         default: return old_v;
      endcase
   endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter with a per-word write port; a write to a word
// overrides that word's increment for the cycle.
module csr_counter64 (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        inc_i,
   input  logic        we_lo_i,
   input  logic        we_hi_i,
   input  logic [31:0] wdata_i,
   output logic [63:0] value_o
);

   logic [31:0] lo_q, lo_d;
   logic [31:0] hi_q, hi_d;
   logic        carry;

   always_comb begin
      // a written low word never carries into the high word that cycle
      carry = inc_i & (&lo_q) & ~we_lo_i;
      lo_d  = we_lo_i ? wdata_i : lo_q + {31'b0, inc_i};
      hi_d  = we_hi_i ? wdata_i : hi_q + {31'b0, carry};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lo_q <= '0;
         hi_q <= '0;
      end else begin
         lo_q <= lo_d;
         hi_q <= hi_d;
      end
   end

   assign value_o = {hi_q, lo_q};

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: combinational read port, writeback-stage write port,
// 64-bit counters and a small trap/mret sequencer producing a pc redirect.
module csr_file
   import csr_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int NUM_HPM     = 2,
   parameter bit VECTORED_EN = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [11:0]     rd_addr,
   output logic [XLEN-1:0] rd_data,
   output logic            rd_illegal,
   input  logic            wr_en,
   input  logic [1:0]      wr_op,
   input  logic [11:0]     wr_addr,
   input  logic [XLEN-1:0] wr_data,
   output logic            wr_illegal,
   input  logic            instret,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_cause,
   input  logic [XLEN-1:0] trap_pc,
   input  logic [XLEN-1:0] trap_tval,
   input  logic            mret_valid,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            mie_global
);

   localparam int          HPM_SZ     = (NUM_HPM > 0) ? NUM_HPM : 1;
   localparam logic [31:0] MTVEC_MASK = VECTORED_EN ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;

   csr_state_e  state_q, state_d;
   logic [31:0] mstatus_q, mstatus_d;
   logic [31:0] mie_q, mie_d;
   logic [31:0] mtvec_q, mtvec_d;
   logic [31:0] mscratch_q, mscratch_d;
   logic [31:0] mepc_q, mepc_d;
   logic [31:0] mcause_q, mcause_d;
   logic [31:0] mtval_q, mtval_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;

   logic [63:0]        mcycle_v, minstret_v;
   logic [63:0]        hpm_v [HPM_SZ];
   logic               cyc_we_lo, cyc_we_hi, ins_we_lo, ins_we_hi;
   logic [HPM_SZ-1:0]  hpm_we_lo, hpm_we_hi;

   csr_rd_t     rd_lk, wr_lk;
   wr_op_e      op_w;
   logic        wr_req, wr_ro, wr_nochange, wr_bad;
   logic        trap_acc, mret_acc, wr_acc;
   logic [31:0] wr_new, trap_base, trap_target;

   function automatic csr_rd_t csr_lookup(input logic [11:0] a);
      csr_rd_t r;
      r.hit  = 1'b1;
      r.data = '0;
      case (a)
         CSR_MSTATUS:               r.data = mstatus_q;
         CSR_MIE:                   r.data = mie_q;
         CSR_MTVEC:                 r.data = mtvec_q;
         CSR_MSCRATCH:              r.data = mscratch_q;
         CSR_MEPC:                  r.data = mepc_q;
         CSR_MCAUSE:                r.data = mcause_q;
         CSR_MTVAL:                 r.data = mtval_q;
         CSR_MIP:                   r.data = '0;
         CSR_MCYCLE, CSR_CYCLE:     r.data = mcycle_v[31:0];
         CSR_MCYCLEH, CSR_CYCLEH:   r.data = mcycle_v[63:32];
         CSR_MINSTRET, CSR_INSTRET: r.data = minstret_v[31:0];
         CSR_MINSTRETH, CSR_INSTRETH: r.data = minstret_v[63:32];
         default: begin
            r.hit = 1'b0;
            for (int i = 0; i < HPM_SZ; i++) begin
               if (i < NUM_HPM) begin
                  if (a == CSR_MHPM_BASE + 12'(i)) begin
                     r.hit  = 1'b1;
                     r.data = hpm_v[i][31:0];
                  end
                  if (a == CSR_MHPMH_BASE + 12'(i)) begin
                     r.hit  = 1'b1;
                     r.data = hpm_v[i][63:32];
                  end
               end
            end
         end
      endcase
      return r;
   endfunction

   always_comb begin
      rd_lk = csr_lookup(rd_addr);
      wr_lk = csr_lookup(wr_addr);
   end

   assign rd_data    = rd_lk.data;
   assign rd_illegal = ~rd_lk.hit;

   // set/clear with a zero mask is a pure read and is legal on read-only CSRs
   always_comb begin
      op_w        = wr_op_e'(wr_op);
      wr_req      = wr_en & (op_w != WR_NONE);
      wr_ro       = (wr_addr[11:10] == 2'b11);
      wr_nochange = (op_w != WR_RW) && (wr_data == '0);
      wr_bad      = ~wr_lk.hit | (wr_ro & ~wr_nochange);
      trap_acc    = trap_valid & (state_q == ST_IDLE);
      mret_acc    = mret_valid & (state_q == ST_IDLE) & ~trap_valid;
      wr_acc      = wr_req & ~wr_bad & ~trap_acc & ~mret_acc;
      wr_new      = csr_apply_op(op_w, wr_lk.data, wr_data);
      trap_base   = {mtvec_q[31:2], 2'b00};
      trap_target = ((mtvec_q[1:0] == 2'b01) && trap_cause[31])
                    ? trap_base + {25'b0, trap_cause[4:0], 2'b00} : trap_base;
   end

   assign wr_illegal = wr_req & wr_bad;

   always_comb begin
      state_d       = ST_IDLE;
      mstatus_d     = mstatus_q;
      mie_d         = mie_q;
      mtvec_d       = mtvec_q;
      mscratch_d    = mscratch_q;
      mepc_d        = mepc_q;
      mcause_d      = mcause_q;
      mtval_d       = mtval_q;
      redirect_pc_d = redirect_pc_q;
      cyc_we_lo     = 1'b0;
      cyc_we_hi     = 1'b0;
      ins_we_lo     = 1'b0;
      ins_we_hi     = 1'b0;
      hpm_we_lo     = '0;
      hpm_we_hi     = '0;
      if (trap_acc) begin
         state_d                = ST_TRAP;
         mepc_d                 = trap_pc & MEPC_MASK;
         mcause_d               = trap_cause;
         mtval_d                = trap_tval;
         mstatus_d[MSTATUS_MPIE] = mstatus_q[MSTATUS_MIE];
         mstatus_d[MSTATUS_MIE]  = 1'b0;
         redirect_pc_d          = trap_target;
      end else if (mret_acc) begin
         state_d                = ST_MRET;
         mstatus_d[MSTATUS_MIE]  = mstatus_q[MSTATUS_MPIE];
         mstatus_d[MSTATUS_MPIE] = 1'b1;
         redirect_pc_d          = mepc_q;
      end else if (wr_acc) begin
         case (wr_addr)
            CSR_MSTATUS:   mstatus_d  = (wr_new & MSTATUS_WMASK) | MSTATUS_RESET;
            CSR_MIE:       mie_d      = wr_new;
            CSR_MTVEC:     mtvec_d    = wr_new & MTVEC_MASK;
            CSR_MSCRATCH:  mscratch_d = wr_new;
            CSR_MEPC:      mepc_d     = wr_new & MEPC_MASK;
            CSR_MCAUSE:    mcause_d   = wr_new;
            CSR_MTVAL:     mtval_d    = wr_new;
            CSR_MCYCLE:    cyc_we_lo  = 1'b1;
            CSR_MCYCLEH:   cyc_we_hi  = 1'b1;
            CSR_MINSTRET:  ins_we_lo  = 1'b1;
            CSR_MINSTRETH: ins_we_hi  = 1'b1;
            default: begin
               for (int i = 0; i < HPM_SZ; i++) begin
                  if (i < NUM_HPM) begin
                     hpm_we_lo[i] = (wr_addr == CSR_MHPM_BASE + 12'(i));
                     hpm_we_hi[i] = (wr_addr == CSR_MHPMH_BASE + 12'(i));
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         mstatus_q     <= MSTATUS_RESET;
         mie_q         <= '0;
         mtvec_q       <= '0;
         mscratch_q    <= '0;
         mepc_q        <= '0;
         mcause_q      <= '0;
         mtval_q       <= '0;
         redirect_pc_q <= '0;
      end else begin
         state_q       <= state_d;
         mstatus_q     <= mstatus_d;
         mie_q         <= mie_d;
         mtvec_q       <= mtvec_d;
         mscratch_q    <= mscratch_d;
         mepc_q        <= mepc_d;
         mcause_q      <= mcause_d;
         mtval_q       <= mtval_d;
         redirect_pc_q <= redirect_pc_d;
      end
   end

   csr_counter64 u_mcycle (
      .clk_i(clk), .rst_ni(reset), .inc_i(1'b1),
      .we_lo_i(cyc_we_lo), .we_hi_i(cyc_we_hi), .wdata_i(wr_new), .value_o(mcycle_v)
   );

   csr_counter64 u_minstret (
      .clk_i(clk), .rst_ni(reset), .inc_i(instret),
      .we_lo_i(ins_we_lo), .we_hi_i(ins_we_hi), .wdata_i(wr_new), .value_o(minstret_v)
   );

   // hpm counters have no event source and only change when written
   for (genvar g = 0; g < HPM_SZ; g++) begin : g_hpm
      if (g < NUM_HPM) begin : g_cnt
         csr_counter64 u_hpm (
            .clk_i(clk), .rst_ni(reset), .inc_i(1'b0),
            .we_lo_i(hpm_we_lo[g]), .we_hi_i(hpm_we_hi[g]), .wdata_i(wr_new), .value_o(hpm_v[g])
         );
      end else begin : g_none
         assign hpm_v[g] = '0;
      end
   end

   assign redirect_valid = (state_q != ST_IDLE);
   assign redirect_pc    = redirect_pc_q;
   assign mie_global     = mstatus_q[MSTATUS_MIE];

endmodule
